fm_demod: RTL



---
 rtl/fm_demod_pkg.sv | 45 ++++
 rtl/fm_demod_div_iter.sv | 75 +++++++
 rtl/fm_demod.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/fm_demod_pkg.sv
// Shared constants, Q10 helpers and FSM state type for the FM discriminator.
// Configuration macro: FM_DEMOD_GAIN_EN (enables the demod gain multiplier).
package fm_demod_pkg;

    localparam int QUANT_VAL     = 10;
    localparam int QUAD1         = 804;
    localparam int QUAD3         = 2412;
    localparam int FM_DEMOD_GAIN = 758;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMULT,
        S_DIV,
        S_DWAIT,
        S_ANGLE,
        S_WRITE
    } fm_demod_state_t;

    function automatic logic signed [31:0] quantize(
        input logic signed [31:0] x
    );
        return x <<< QUANT_VAL;
    endfunction

    // Bias negatives before the shift so the result truncates toward zero.
    function automatic logic signed [31:0] dequantize(
        input logic signed [63:0] x
    );
        logic signed [63:0] b;
        b = x + (x[63] ? 64'sd1023 : 64'sd0);
        return 32'(b >>> QUANT_VAL);
    endfunction

    function automatic logic signed [63:0] mul64(
        input logic signed [31:0] a,
        input logic signed [31:0] b
    );
        logic signed [63:0] a_w;
        logic signed [63:0] b_w;
        a_w = 64'(a);
        b_w = 64'(b);
        return a_w * b_w;
    endfunction

endpackage

// File: rtl/fm_demod_div_iter.sv
// Signed restoring divider, one quotient bit per cycle, quotient toward zero.
// Fixed DIV_BITS+1 cycle latency from start to the one-cycle done pulse.
module div_iter #(
    parameter int DIV_BITS = 32
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic signed [DIV_BITS-1:0] dividend,
    input  logic signed [DIV_BITS-1:0] divisor,
    output logic signed [DIV_BITS-1:0] quotient,
    output logic                       done
);

    localparam int CW = $clog2(DIV_BITS + 1);

    logic [DIV_BITS-1:0] quo_q;
    logic [DIV_BITS-1:0] den_q;
    logic [DIV_BITS-1:0] rem_q;
    logic                neg_q;
    logic                zero_q;
    logic                busy_q;
    logic [CW-1:0]       cnt_q;

    logic [DIV_BITS:0]   rem_sh;
    logic [DIV_BITS:0]   rem_sub;
    logic                fits;

    always_comb begin
        rem_sh  = {rem_q, quo_q[DIV_BITS-1]};
        rem_sub = rem_sh - {1'b0, den_q};
        fits    = !rem_sub[DIV_BITS];
    end

    always_comb begin
        quotient = '0;
        if (!zero_q)
            quotient = neg_q ? $signed(-quo_q) : $signed(quo_q);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            quo_q  <= '0;
            den_q  <= '0;
            rem_q  <= '0;
            neg_q  <= 1'b0;
            zero_q <= 1'b0;
            busy_q <= 1'b0;
            cnt_q  <= '0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (start) begin
                quo_q  <= dividend[DIV_BITS-1] ?
                          DIV_BITS'(-dividend) : DIV_BITS'(dividend);
                den_q  <= divisor[DIV_BITS-1] ?
                          DIV_BITS'(-divisor) : DIV_BITS'(divisor);
                rem_q  <= '0;
                neg_q  <= dividend[DIV_BITS-1] ^ divisor[DIV_BITS-1];
                zero_q <= (divisor == '0);
                cnt_q  <= CW'(DIV_BITS);
                busy_q <= 1'b1;
            end else if (busy_q) begin
                rem_q <= fits ? rem_sub[DIV_BITS-1:0] : rem_sh[DIV_BITS-1:0];
                quo_q <= {quo_q[DIV_BITS-2:0], fits};
                cnt_q <= cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    busy_q <= 1'b0;
                    done   <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fm_demod.sv
// FM discriminator: conj-multiply, quantized atan via divider, optional gain.
// Configuration macro: FM_DEMOD_GAIN_EN (undefined: output is the raw angle).
module fm_demod
    import fm_demod_pkg::*;
#(
`ifdef FM_DEMOD_GAIN_EN
    parameter int GAIN     = FM_DEMOD_GAIN,
`endif
    parameter int DIV_BITS = 32
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic signed [31:0] real_in,
    input  logic signed [31:0] imag_in,
    output logic               real_rd_en,
    output logic               imag_rd_en,
    input  logic               real_empty,
    input  logic               imag_empty,
    output logic signed [31:0] demod_out,
    output logic               demod_wr_en,
    input  logic               demod_full
);

    fm_demod_state_t state_q;

    logic signed [31:0] cr_q;
    logic signed [31:0] ci_q;
    logic signed [31:0] pr_q;
    logic signed [31:0] pi_q;
    logic signed [31:0] num_q;
    logic signed [31:0] den_q;
    logic signed [31:0] q_q;
    logic signed [31:0] res_q;
    logic               r_neg_q;
    logic               i_neg_q;

    logic signed [31:0] r_c;
    logic signed [31:0] i_c;
    logic signed [31:0] ay_c;
    logic signed [31:0] num_c;
    logic signed [31:0] den_c;
    logic signed [31:0] quad_c;
    logic signed [31:0] a_c;
    logic signed [31:0] res_c;

    logic               pop;
    logic               div_start;
    logic               div_done;
    logic signed [31:0] div_quo;

    assign pop = reset_n && (state_q == S_IDLE) && !real_empty && !imag_empty;
    assign real_rd_en  = pop;
    assign imag_rd_en  = pop;
    assign demod_wr_en = (state_q == S_WRITE) && !demod_full;
    assign demod_out   = res_q;
    assign div_start   = (state_q == S_DIV);

    // Product with the conjugate of the previous sample.
    always_comb begin
        r_c  = dequantize(mul64(pr_q, cr_q)) - dequantize(-mul64(pi_q, ci_q));
        i_c  = dequantize(mul64(pr_q, ci_q)) + dequantize(-mul64(pi_q, cr_q));
        ay_c = (i_c[31] ? -i_c : i_c) + 32'sd1;
        if (!r_c[31]) begin
            num_c = quantize(r_c - ay_c);
            den_c = r_c + ay_c;
        end else begin
            num_c = quantize(r_c + ay_c);
            den_c = ay_c - r_c;
        end
    end

    always_comb begin
        quad_c = r_neg_q ? 32'(QUAD3) : 32'(QUAD1);
        a_c    = quad_c - dequantize(mul64(32'(QUAD1), q_q));
        if (i_neg_q)
            a_c = -a_c;
`ifdef FM_DEMOD_GAIN_EN
        res_c = dequantize(mul64(32'(GAIN), a_c));
`else
        res_c = a_c;
`endif
    end

    div_iter #(
        .DIV_BITS (DIV_BITS)
    ) u_div (
        .clock    (clock),
        .reset_n  (reset_n),
        .start    (div_start),
        .dividend (num_q),
        .divisor  (den_q),
        .quotient (div_quo),
        .done     (div_done)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            cr_q    <= '0;
            ci_q    <= '0;
            pr_q    <= '0;
            pi_q    <= '0;
            num_q   <= '0;
            den_q   <= '0;
            q_q     <= '0;
            res_q   <= '0;
            r_neg_q <= 1'b0;
            i_neg_q <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        cr_q    <= real_in;
                        ci_q    <= imag_in;
                        state_q <= S_CMULT;
                    end
                end
                S_CMULT: begin
                    num_q   <= num_c;
                    den_q   <= den_c;
                    r_neg_q <= r_c[31];
                    i_neg_q <= i_c[31];
                    pr_q    <= cr_q;
                    pi_q    <= ci_q;
                    state_q <= S_DIV;
                end
                S_DIV: state_q <= S_DWAIT;
                S_DWAIT: begin
                    if (div_done) begin
                        q_q     <= div_quo;
                        state_q <= S_ANGLE;
                    end
                end
                S_ANGLE: begin
                    res_q   <= res_c;
                    state_q <= S_WRITE;
                end
                S_WRITE: begin
                    if (!demod_full)
                        state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
